// File: rtl/addrreg_sequencer_if.sv
// Command handshake and register-control bus between the control unit and the
// address register sequencer.
interface addrreg_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        busy;
  logic        done;
  logic [15:0] LOAD_DATA;
  logic        LOAD_bar;
  logic [1:0]  DIRECTION;
  logic        CNT_CLK;
  logic        ASSERT_bar;
  logic [15:0] shadow_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, busy, done, LOAD_DATA, LOAD_bar, DIRECTION,
           CNT_CLK, ASSERT_bar, shadow_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, busy, done, LOAD_DATA, LOAD_bar, DIRECTION,
           CNT_CLK, ASSERT_bar, shadow_addr
  );
endinterface

// File: rtl/addrreg_sequencer.sv
// Sequences LOAD/INC/DEC/ASSERT commands into framed strobes for one 16-bit
// address register and tracks the value the register should now hold.
module addrreg_sequencer #(
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  addrreg_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_ASSERT, S_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_INC    = 2'd1;
  localparam logic [1:0] OP_DEC    = 2'd2;
  localparam logic [1:0] OP_ASSERT = 2'd3;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  state_t      state;
  logic [15:0] remaining;

  // Ready is only a decode of the state register, gated off while reset is held.
  assign bus.cmd_ready = (state == S_IDLE) && !RST;
  assign bus.busy      = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= S_IDLE;
      remaining       <= '0;
      bus.done        <= 1'b0;
      bus.LOAD_DATA   <= '0;
      bus.LOAD_bar    <= 1'b1;
      bus.DIRECTION   <= DIR_NONE;
      bus.CNT_CLK     <= 1'b1;
      bus.ASSERT_bar  <= 1'b1;
      bus.shadow_addr <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_LOAD: begin
                bus.LOAD_DATA <= bus.cmd_data;
                bus.LOAD_bar  <= 1'b0;
                remaining     <= 16'(LOAD_CYCLES - 1);
                state         <= S_LOAD;
              end
              OP_INC, OP_DEC: begin
                if (bus.cmd_data == 16'd0) begin
                  bus.done <= 1'b1;
                  state    <= S_DONE;
                end else begin
                  bus.DIRECTION <= (bus.cmd_op == OP_INC) ? DIR_UP : DIR_DOWN;
                  remaining     <= bus.cmd_data;
                  state         <= S_SETUP;
                end
              end
              default: begin
                if (bus.cmd_data == 16'd0) begin
                  bus.done <= 1'b1;
                  state    <= S_DONE;
                end else begin
                  bus.ASSERT_bar <= 1'b0;
                  remaining      <= bus.cmd_data - 16'd1;
                  state          <= S_ASSERT;
                end
              end
            endcase
          end
        end

        S_LOAD: begin
          if (remaining == 16'd0) begin
            bus.LOAD_bar    <= 1'b1;
            bus.shadow_addr <= bus.LOAD_DATA;
            bus.done        <= 1'b1;
            state           <= S_DONE;
          end else begin
            remaining <= remaining - 16'd1;
          end
        end

        S_SETUP: begin
          bus.CNT_CLK <= 1'b0;
          state       <= S_PULSE;
        end

        // The counted edge happens here, so the shadow copy follows it.
        S_PULSE: begin
          bus.CNT_CLK <= 1'b1;
          remaining   <= remaining - 16'd1;
          if (bus.DIRECTION == DIR_UP)
            bus.shadow_addr <= bus.shadow_addr + 16'd1;
          else
            bus.shadow_addr <= bus.shadow_addr - 16'd1;
          state <= S_HOLD;
        end

        S_HOLD: begin
          if (remaining == 16'd0) begin
            bus.DIRECTION <= DIR_NONE;
            bus.done      <= 1'b1;
            state         <= S_DONE;
          end else begin
            state <= S_SETUP;
          end
        end

        S_ASSERT: begin
          if (remaining == 16'd0) begin
            bus.ASSERT_bar <= 1'b1;
            bus.done       <= 1'b1;
            state          <= S_DONE;
          end else begin
            remaining <= remaining - 16'd1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addrreg_sequencer.sv
// Directed bench for addrreg_sequencer: reset, load, count with wrap, assert,
// back-to-back commands and reset abort.
module tb_addrreg_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   last_wait;

  addrreg_sequencer_if bus();

  addrreg_sequencer #(.LOAD_CYCLES(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, then measures strobes cycle by cycle until done.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] data,
                         output int done_cyc, output int load_low,
                         output int pulses, output int assert_low,
                         output int up_cyc, output int dn_cyc,
                         output int viol, output logic [15:0] first_data);
    int active;
    done_cyc = -1; load_low = 0; pulses = 0; assert_low = 0;
    up_cyc = 0; dn_cyc = 0; viol = 0; first_data = 16'hxxxx;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
    last_wait = 0;
    while (!bus.cmd_ready && last_wait < 50) begin
      tick();
      last_wait++;
    end
    if (!bus.cmd_ready) begin
      checks++; failures++;
      $display("[TB] FAIL accept_timeout op=%0d got_ready=%b exp_ready=1", op, bus.cmd_ready);
      bus.cmd_valid = 1'b0;
      return;
    end
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      active = 0;
      if (bus.LOAD_bar === 1'b0) begin load_low++; active++; end
      if (bus.CNT_CLK === 1'b0) begin pulses++; active++; end
      if (bus.ASSERT_bar === 1'b0) begin assert_low++; active++; end
      if (active > 1 || bus.DIRECTION === 2'd3) viol++;
      if (bus.DIRECTION === 2'd1) up_cyc++;
      if (bus.DIRECTION === 2'd2) dn_cyc++;
      if (c == 1) first_data = bus.LOAD_DATA;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_data = 16'h0000;
    tick(); tick();
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", bus.cmd_ready); end
    checks++; if ({bus.LOAD_bar, bus.ASSERT_bar, bus.CNT_CLK} !== 3'b111) begin failures++; $display("[TB] FAIL reset_strobes got=%b exp=111", {bus.LOAD_bar, bus.ASSERT_bar, bus.CNT_CLK}); end
    checks++; if ({bus.DIRECTION, bus.done, bus.busy} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_dir_done_busy got=%b exp=0000", {bus.DIRECTION, bus.done, bus.busy}); end
    checks++; if ({bus.LOAD_DATA, bus.shadow_addr} !== 32'h0) begin failures++; $display("[TB] FAIL reset_data_shadow got=%h exp=00000000", {bus.LOAD_DATA, bus.shadow_addr}); end
    rst = 1'b0;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_reset got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_load();
    int dc, ll, pl, al, up, dn, vi;
    logic [15:0] fd;
    run_cmd(2'd0, 16'h1234, dc, ll, pl, al, up, dn, vi, fd);
    checks++; if (dc !== 3) begin failures++; $display("[TB] FAIL load_done_cycle got=%0d exp=3", dc); end
    checks++; if (ll !== 2) begin failures++; $display("[TB] FAIL load_bar_low_cycles got=%0d exp=2", ll); end
    checks++; if (fd !== 16'h1234) begin failures++; $display("[TB] FAIL load_data_cycle1 got=%h exp=1234", fd); end
    checks++; if (bus.shadow_addr !== 16'h1234) begin failures++; $display("[TB] FAIL load_shadow got=%h exp=1234", bus.shadow_addr); end
    checks++; if (pl + al + vi + up + dn !== 0) begin failures++; $display("[TB] FAIL load_other_strobes got=%0d exp=0", pl + al + vi + up + dn); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.LOAD_DATA !== 16'h1234) begin failures++; $display("[TB] FAIL load_after got=%b/%h exp=0/1234", bus.done, bus.LOAD_DATA); end
  endtask

  task automatic test_inc_wrap();
    int dc, ll, pl, al, up, dn, vi;
    logic [15:0] fd;
    run_cmd(2'd0, 16'hFFFE, dc, ll, pl, al, up, dn, vi, fd);
    checks++; if (bus.shadow_addr !== 16'hFFFE) begin failures++; $display("[TB] FAIL inc_preload got=%h exp=fffe", bus.shadow_addr); end
    run_cmd(2'd1, 16'd3, dc, ll, pl, al, up, dn, vi, fd);
    checks++; if (dc !== 10) begin failures++; $display("[TB] FAIL inc3_done_cycle got=%0d exp=10", dc); end
    checks++; if (pl !== 3) begin failures++; $display("[TB] FAIL inc3_pulses got=%0d exp=3", pl); end
    checks++; if (up !== 9 || dn !== 0) begin failures++; $display("[TB] FAIL inc3_direction got=%0d/%0d exp=9/0", up, dn); end
    checks++; if (bus.shadow_addr !== 16'h0001) begin failures++; $display("[TB] FAIL inc3_shadow got=%h exp=0001", bus.shadow_addr); end
    checks++; if (vi !== 0 || bus.DIRECTION !== 2'd0) begin failures++; $display("[TB] FAIL inc3_exclusive got=%0d/%0d exp=0/0", vi, bus.DIRECTION); end
  endtask

  task automatic test_dec();
    int dc, ll, pl, al, up, dn, vi;
    logic [15:0] fd;
    run_cmd(2'd0, 16'h0001, dc, ll, pl, al, up, dn, vi, fd);
    run_cmd(2'd2, 16'd2, dc, ll, pl, al, up, dn, vi, fd);
    checks++; if (dc !== 7) begin failures++; $display("[TB] FAIL dec2_done_cycle got=%0d exp=7", dc); end
    checks++; if (pl !== 2) begin failures++; $display("[TB] FAIL dec2_pulses got=%0d exp=2", pl); end
    checks++; if (dn !== 6 || up !== 0) begin failures++; $display("[TB] FAIL dec2_direction got=%0d/%0d exp=6/0", dn, up); end
    checks++; if (bus.shadow_addr !== 16'hFFFF) begin failures++; $display("[TB] FAIL dec2_shadow got=%h exp=ffff", bus.shadow_addr); end
    run_cmd(2'd2, 16'd0, dc, ll, pl, al, up, dn, vi, fd);
    checks++; if (dc !== 1) begin failures++; $display("[TB] FAIL dec0_done_cycle got=%0d exp=1", dc); end
    checks++; if (pl + up + dn !== 0 || bus.shadow_addr !== 16'hFFFF) begin failures++; $display("[TB] FAIL dec0_no_pulse got=%0d/%h exp=0/ffff", pl + up + dn, bus.shadow_addr); end
  endtask

  task automatic test_back_to_back();
    int dc, ll, pl, al, up, dn, vi;
    logic [15:0] fd;
    run_cmd(2'd1, 16'd1, dc, ll, pl, al, up, dn, vi, fd);
    checks++; if (last_wait !== 1) begin failures++; $display("[TB] FAIL b2b_accept_wait got=%0d exp=1", last_wait); end
    checks++; if (dc !== 4 || bus.shadow_addr !== 16'h0000) begin failures++; $display("[TB] FAIL inc1_wrap got=%0d/%h exp=4/0000", dc, bus.shadow_addr); end
    run_cmd(2'd3, 16'd0, dc, ll, pl, al, up, dn, vi, fd);
    checks++; if (dc !== 1 || al !== 0) begin failures++; $display("[TB] FAIL assert0 got=%0d/%0d exp=1/0", dc, al); end
    run_cmd(2'd0, 16'h00A5, dc, ll, pl, al, up, dn, vi, fd);
    checks++; if (dc !== 3 || bus.shadow_addr !== 16'h00A5) begin failures++; $display("[TB] FAIL b2b_load got=%0d/%h exp=3/00a5", dc, bus.shadow_addr); end
  endtask

  task automatic test_assert_hold_valid();
    int al, early, bad_data, dc, waitc;
    al = 0; early = 0; bad_data = 0; dc = -1; waitc = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3; bus.cmd_data = 16'd4;
    while (!bus.cmd_ready && waitc < 50) begin tick(); waitc++; end
    tick();
    bus.cmd_op = 2'd0; bus.cmd_data = 16'hBEEF;
    for (int c = 1; c <= 5; c++) begin
      if (bus.ASSERT_bar === 1'b0) al++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) early++;
      if (bus.LOAD_DATA !== 16'h00A5 || bus.LOAD_bar !== 1'b1) bad_data++;
      if (bus.done === 1'b1 && dc < 0) dc = c;
      if (c < 5) tick();
    end
    checks++; if (al !== 4) begin failures++; $display("[TB] FAIL assert4_low_cycles got=%0d exp=4", al); end
    checks++; if (dc !== 5) begin failures++; $display("[TB] FAIL assert4_done_cycle got=%0d exp=5", dc); end
    checks++; if (early !== 0 || bad_data !== 0) begin failures++; $display("[TB] FAIL assert4_busy_ignore got=%0d/%0d exp=0/0", early, bad_data); end
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL assert4_idle got=%b/%b exp=1/0", bus.cmd_ready, bus.busy); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.LOAD_bar !== 1'b0 || bus.LOAD_DATA !== 16'hBEEF) begin failures++; $display("[TB] FAIL second_cmd got=%b/%h exp=0/beef", bus.LOAD_bar, bus.LOAD_DATA); end
    tick(); tick();
    checks++; if (bus.done !== 1'b1 || bus.shadow_addr !== 16'hBEEF) begin failures++; $display("[TB] FAIL second_cmd_done got=%b/%h exp=1/beef", bus.done, bus.shadow_addr); end
  endtask

  task automatic test_reset_abort();
    int waitc, late;
    waitc = 0; late = 0;
    tick();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_data = 16'd5;
    while (!bus.cmd_ready && waitc < 50) begin tick(); waitc++; end
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (bus.CNT_CLK !== 1'b0 || bus.DIRECTION !== 2'd1) begin failures++; $display("[TB] FAIL abort_second_pulse got=%b/%0d exp=0/1", bus.CNT_CLK, bus.DIRECTION); end
    tick();
    checks++; if (bus.shadow_addr !== 16'hBEF1) begin failures++; $display("[TB] FAIL abort_shadow_before got=%h exp=bef1", bus.shadow_addr); end
    rst = 1'b1;
    tick();
    checks++; if (bus.shadow_addr !== 16'h0000 || bus.LOAD_DATA !== 16'h0000) begin failures++; $display("[TB] FAIL abort_shadow got=%h/%h exp=0000/0000", bus.shadow_addr, bus.LOAD_DATA); end
    checks++; if ({bus.CNT_CLK, bus.LOAD_bar, bus.ASSERT_bar, bus.DIRECTION, bus.busy, bus.done, bus.cmd_ready} !== 8'b11100000) begin failures++; $display("[TB] FAIL abort_outputs got=%b exp=11100000", {bus.CNT_CLK, bus.LOAD_bar, bus.ASSERT_bar, bus.DIRECTION, bus.busy, bus.done, bus.cmd_ready}); end
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.CNT_CLK !== 1'b1 || bus.busy !== 1'b0) late++;
    end
    checks++; if (late !== 0) begin failures++; $display("[TB] FAIL abort_no_more_pulses got=%0d exp=0", late); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_wait = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_data = 16'h0000;
    #1;
    test_reset();
    test_load();
    test_inc_wrap();
    test_dec();
    test_back_to_back();
    test_assert_hold_valid();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
